ahb_resp_mux: RTL

//  AHB-Lite return path paired with ahb_decoder: registers the address-phase slave

---
 rtl/ahb_pkg.sv | 38 +++
 rtl/ahb_default_slave.sv | 48 ++++
 rtl/ahb_resp_mux.sv | 103 ++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the response mux and its default slave:
// HTRANS/HRESP codes, data-phase slave index, default-slave FSM states.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SLV_ROM    = 2'd0,
        SLV_RAM    = 2'd1,
        SLV_BRIDGE = 2'd2,
        SLV_DEF    = 2'd3
    } slv_e;

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } def_state_e;

    // Non-one-hot selects resolve rom > ram > bridge; anything else is unmapped.
    function automatic slv_e resolve_sel(input logic rom, input logic ram, input logic bridge);
        if (rom)         return SLV_ROM;
        else if (ram)    return SLV_RAM;
        else if (bridge) return SLV_BRIDGE;
        else             return SLV_DEF;
    endfunction

    function automatic logic is_transfer(input logic [1:0] htrans);
        return (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: answers every accepted NONSEQ/SEQ
// with the two-cycle AHB ERROR response; IDLE/BUSY get a zero-wait OKAY.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       hclk_i,
    input  logic       hreset_i,
    input  logic       hsel_i,
    input  logic [1:0] htrans_i,
    input  logic       hready_i,
    output logic       hreadyout_o,
    output logic       hresp_o
);

    def_state_e state_q, state_d;
    logic       accept;

    assign accept = hsel_i && is_transfer(htrans_i) && hready_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk_i) begin
        if (hreset_i) state_q <= DEF_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
        case (state_q)
            DEF_IDLE: begin
                if (accept) state_d = DEF_ERR1;
            end
            DEF_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
                state_d     = DEF_ERR2;
            end
            DEF_ERR2: begin
                hresp_o = HRESP_ERROR;
                state_d = accept ? DEF_ERR1 : DEF_IDLE;
            end
            default: state_d = DEF_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response mux: registers the address-phase select and steers the data-phase
// HRDATA/HREADY/HRESP back to the master. Optional ERROR counter under AHB_RESP_ERRCNT_EN.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_hsel_rom,
    input  logic              i_hsel_ram,
    input  logic              i_hsel_bridge,
    input  logic              i_hsel_def,
    input  logic [1:0]        i_htrans,
    input  logic [DATA_W-1:0] i_hrdata_rom,
    input  logic [DATA_W-1:0] i_hrdata_ram,
    input  logic [DATA_W-1:0] i_hrdata_bridge,
    input  logic              i_hreadyout_rom,
    input  logic              i_hreadyout_ram,
    input  logic              i_hreadyout_bridge,
    input  logic              i_hresp_rom,
    input  logic              i_hresp_ram,
    input  logic              i_hresp_bridge,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_hrdata,
    output logic              o_hready,
    output logic              o_hresp,
    output logic [CNT_W-1:0]  o_err_cnt
);

    slv_e sel_addr, dsel_q, dsel_d;
    logic def_hreadyout, def_hresp;

    assign sel_addr = resolve_sel(i_hsel_rom, i_hsel_ram, i_hsel_bridge);

    // Address-phase select only advances on a completed transfer; wait states hold it.
    always_comb dsel_d = o_hready ? sel_addr : dsel_q;

    always_ff @(posedge i_hclk) begin
        if (i_hreset) dsel_q <= SLV_DEF;
        else          dsel_q <= dsel_d;
    end

    ahb_default_slave u_default_slave (
        .hclk_i      (i_hclk),
        .hreset_i    (i_hreset),
        .hsel_i      (i_hsel_def && (sel_addr == SLV_DEF)),
        .htrans_i    (i_htrans),
        .hready_i    (o_hready),
        .hreadyout_o (def_hreadyout),
        .hresp_o     (def_hresp)
    );

    always_comb begin
        o_hrdata = '0;
        o_hready = def_hreadyout;
        o_hresp  = def_hresp;
        case (dsel_q)
            SLV_ROM: begin
                o_hrdata = i_hrdata_rom;
                o_hready = i_hreadyout_rom;
                o_hresp  = i_hresp_rom;
            end
            SLV_RAM: begin
                o_hrdata = i_hrdata_ram;
                o_hready = i_hreadyout_ram;
                o_hresp  = i_hresp_ram;
            end
            SLV_BRIDGE: begin
                o_hrdata = i_hrdata_bridge;
                o_hready = i_hreadyout_bridge;
                o_hresp  = i_hresp_bridge;
            end
            default: ;
        endcase
    end

`ifdef AHB_RESP_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts the final (HREADY high) cycle of each ERROR response, saturating.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (i_err_clr)
            err_cnt_d = '0;
        else if (o_hready && o_hresp && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) err_cnt_q <= '0;
        else          err_cnt_q <= err_cnt_d;
    end

    assign o_err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_err_cnt      = '0;
`endif

endmodule
